mdr_seq_ctrl: RTL and testbench
===============================

# mdr_seq_ctrl

Sequencing controller for the iterative multiply/divide/square-root (MDR) datapath. It accepts an operation request through a ready/start handshake and drives the 2-bit select of the 3:1 accumulator-input multiplexer and the accumulator load enable. Each operation runs as initial load, then N iteration cycles, then a completion or error pulse. It sits directly upstream of the accumulator-input 3:1 mux, which selects A = initial operand, B = iteration result, C = zero/clear.

## Interface
Parameters:
- DW, mdr_pkg::DW (16): operand width; sets iteration count.
- CNT_W, $clog2(DW)+1: iteration counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; accepted only when ready=1.
- op  in  2  operation code, sampled with accepted start: 00 MULT, 01 DIV, 10 SQRT, 11 illegal.
- divisor_zero  in  1  DIV operand is zero; sampled with accepted start.
- mux_sel  out  2  to the 3:1 mux: 00 = A, 01 = B, 1x = C.
- acc_load  out  1  accumulator load enable.
- iter_cnt  out  CNT_W  current iteration index.
- op_q  out  2  latched op code.
- ready  out  1  idle and able to accept start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle error pulse, coincident with done.

## Operation
States are IDLE, LOAD, ITER, DONE and ERR.

- **IDLE**
  - ready=1, mux_sel=10, acc_load=0.
  - start=1 with op∈{00,01,10} and not (op=01 and divisor_zero): go to LOAD and latch op_q.
  - start=1 with op=11, or with op=01 and divisor_zero=1: go to ERR and latch op_q.
- **LOAD** (1 cycle)
  - mux_sel=00, acc_load=1, iter_cnt←0; go to ITER.
- **ITER** (N cycles)
  - mux_sel=01, acc_load=1, iter_cnt increments each cycle.
  - N=DW for MULT and DIV; N=DW/2 for SQRT.
  - When iter_cnt=N-1, go to DONE.
- **DONE** (1 cycle)
  - done=1, mux_sel=10, acc_load=0; go to IDLE.
- **ERR** (1 cycle)
  - done=1, error=1, mux_sel=10, acc_load=1 (clears the accumulator); go to IDLE.
- **Flags**
  - busy=1 in LOAD and ITER.
  - ready=1 only in IDLE.
- **Ignored inputs**
  - start is ignored in every state except IDLE; no queuing.
  - op and divisor_zero are ignored outside an accepted start.
- **Counter**
  - iter_cnt holds its last value in DONE, ERR and IDLE.
  - iter_cnt never wraps: the terminal comparison ends ITER first.

## Timing
- Reset (async, rst_n=0): state=IDLE, mux_sel=10, acc_load=0, iter_cnt=0, op_q=00, ready=1, busy=0, done=0, error=0.
- Reset mid-operation: outputs immediately return to the reset values. No done or error pulse is produced.
- Outputs are registered or decoded from the registered state only. There is no combinational path from start to the outputs.
- Start accepted at edge 0 gives the following cycles:
  - LOAD in cycle 1.
  - ITER in cycles 2..N+1.
  - done in cycle N+2.
  - ready in cycle N+3.
- MULT/DIV latency is DW+2 cycles; SQRT latency is DW/2+2 cycles.
- ERR path: error and done are high in cycle 1, ready is high in cycle 2.
- Back-to-back operations: the earliest next start is accepted in the cycle ready returns, giving a throughput of N+3 cycles per operation.

## Structure
- **mdr_pkg** gains:
  - op_e enum (OP_MULT, OP_DIV, OP_SQRT, OP_ILL).
  - state_e enum.
  - SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10 constants.
  - Existing DW and DW_DBL are reused.
- **mdr_iter_counter** sub-module:
  - Loadable up-counter with clear, enable and terminal-count compare against the N input.
  - Same clock and reset as the parent.
- The FSM and output decode live in mdr_seq_ctrl.

## Test plan
All scenarios use DW=16.

- **MULT:** start with op=00 at cycle 0 → mux_sel=00/acc_load=1 at cycle 1; mux_sel=01 for cycles 2..17 with iter_cnt 0..15; done=1 at cycle 18; ready=1 at cycle 19.
- **SQRT:** start with op=10 → exactly 8 ITER cycles; done at cycle 10; error=0 throughout.
- **DIV by zero:** start with op=01 and divisor_zero=1 → done=1, error=1, mux_sel=10, acc_load=1 at cycle 1; ready=1 at cycle 2; no cycle with mux_sel=01.
- **Illegal op:** start with op=11 → same response as DIV by zero; op_q=11.
- **Start while busy:** start pulsed at cycles 5 and 18 during a MULT, with op=10 → no effect; op_q stays 00; done still at 18; a new start at 19 is accepted.
- **Reset mid-operation:** rst_n=0 when iter_cnt=5 → all outputs at reset values within the same cycle; no done pulse; after release a MULT completes in 18 cycles.

Source files
------------

// File: rtl/mdr_pkg.sv
// Shared types and constants for the MDR datapath and its sequencing controller.
// Operand width, op codes, controller states and accumulator-mux select codes.
package mdr_pkg;

    localparam int DW     = 16;
    localparam int DW_DBL = 2 * DW;
    localparam int CNT_W  = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Accumulator-input mux: A = initial operand, B = iteration result, C = clear.
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    // An op that must be refused straight away instead of being iterated.
    function automatic logic is_reject(input op_e op, input logic divisor_zero);
        return (op == OP_ILL) || ((op == OP_DIV) && divisor_zero);
    endfunction

endpackage

// File: rtl/mdr_iter_counter.sv
// Iteration counter for the MDR sequencer: synchronous clear, enable, and a
// terminal-count flag raised when the count reaches n-1.
module mdr_iter_counter #(
    parameter int CNT_W = mdr_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] n,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == (n - CNT_W'(1)));

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            // Stopping at n-1 leaves the last index visible and can never wrap.
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdr_seq_ctrl.sv
// Sequencing controller for the iterative multiply/divide/sqrt datapath: runs
// load, N iterations, then a done (or done+error) pulse per accepted request.
module mdr_seq_ctrl
    import mdr_pkg::*;
#(
    parameter int DW    = mdr_pkg::DW,
    parameter int CNT_W = $clog2(DW) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             divisor_zero,
    output logic [1:0]       mux_sel,
    output logic             acc_load,
    output logic [CNT_W-1:0] iter_cnt,
    output logic [1:0]       op_q,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [CNT_W-1:0] N_FULL = CNT_W'(DW);
    localparam logic [CNT_W-1:0] N_HALF = CNT_W'(DW / 2);

    state_e           state;
    state_e           state_nxt;
    op_e              op_r;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] iter_n;

    assign accept = (state == ST_IDLE) && start;
    assign op_q   = op_r;
    assign iter_n = (op_r == OP_SQRT) ? N_HALF : N_FULL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_r  <= OP_MULT;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_r <= op_e'(op);
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        mux_sel   = SEL_C;
        acc_load  = 1'b0;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = is_reject(op_e'(op), divisor_zero) ? ST_ERR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                mux_sel   = SEL_A;
                acc_load  = 1'b1;
                busy      = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = ST_ITER;
            end
            ST_ITER: begin
                mux_sel  = SEL_B;
                acc_load = 1'b1;
                busy     = 1'b1;
                cnt_en   = 1'b1;
                if (cnt_tc) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                // Loading with the mux on C clears the accumulator.
                done      = 1'b1;
                error     = 1'b1;
                acc_load  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    mdr_iter_counter #(
        .CNT_W(CNT_W)
    ) u_iter_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .n    (iter_n),
        .cnt  (iter_cnt),
        .tc   (cnt_tc)
    );

endmodule

// File: tb/tb_mdr_seq_ctrl.sv
// Self-checking bench for mdr_seq_ctrl: directed scenarios plus randomized
// operations, compared cycle by cycle against a timeline model of each op.
module tb_mdr_seq_ctrl;

    localparam int DW    = 16;
    localparam int CNT_W = $clog2(DW) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic             divisor_zero = 1'b0;
    logic [1:0]       mux_sel;
    logic             acc_load;
    logic [CNT_W-1:0] iter_cnt;
    logic [1:0]       op_q;
    logic             ready;
    logic             busy;
    logic             done;
    logic             error;

    int total = 0;
    int bad   = 0;

    logic [CNT_W-1:0] exp_cnt;
    logic [1:0]       exp_opq;

    mdr_seq_ctrl #(.DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .divisor_zero(divisor_zero),
        .mux_sel     (mux_sel),
        .acc_load    (acc_load),
        .iter_cnt    (iter_cnt),
        .op_q        (op_q),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Compares every output against one expected cycle; cnt_chk=0 skips iter_cnt.
    task automatic chk_cycle(input string tag, input logic [1:0] e_mux, input logic e_load,
                             input logic cnt_chk, input logic [CNT_W-1:0] e_cnt,
                             input logic e_rdy, input logic e_busy, input logic e_done,
                             input logic e_err);
        chk({tag, ".mux_sel"}, 8'(mux_sel), 8'(e_mux));
        chk({tag, ".acc_load"}, 8'(acc_load), 8'(e_load));
        if (cnt_chk) chk({tag, ".iter_cnt"}, 8'(iter_cnt), 8'(e_cnt));
        chk({tag, ".op_q"}, 8'(op_q), 8'(exp_opq));
        chk({tag, ".ready"}, 8'(ready), 8'(e_rdy));
        chk({tag, ".busy"}, 8'(busy), 8'(e_busy));
        chk({tag, ".done"}, 8'(done), 8'(e_done));
        chk({tag, ".error"}, 8'(error), 8'(e_err));
    endtask

    task automatic chk_reset(input string tag);
        exp_opq = 2'b00;
        chk_cycle(tag, 2'b10, 1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Issues one request at the current negedge (an idle cycle) and checks the
    // whole response timeline. noise: 0 none, 1 random starts while busy,
    // 2 starts with op=10 in cycles 5 and n+2. abort_k>0 asserts reset in that cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic dz,
                          input int noise, input int abort_k);
        bit rej;
        int n;
        int last;
        rej  = (o == 2'b11) || (o == 2'b01 && dz);
        n    = (o == 2'b10) ? DW / 2 : DW;
        last = rej ? 2 : n + 3;

        chk_cycle({tag, ".idle"}, 2'b10, 1'b0, 1'b1, exp_cnt, 1'b1, 1'b0, 1'b0, 1'b0);
        start        = 1'b1;
        op           = o;
        divisor_zero = dz;
        @(negedge clk);
        exp_opq = o;

        for (int k = 1; k < last; k++) begin
            if (rej)
                chk_cycle({tag, ".err"}, 2'b10, 1'b1, 1'b1, exp_cnt, 1'b0, 1'b0, 1'b1, 1'b1);
            else if (k == 1)
                chk_cycle({tag, ".load"}, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            else if (k <= n + 1)
                chk_cycle({tag, ".iter"}, 2'b01, 1'b1, 1'b1, CNT_W'(k - 2), 1'b0, 1'b1, 1'b0, 1'b0);
            else
                chk_cycle({tag, ".done"}, 2'b10, 1'b0, 1'b1, CNT_W'(n - 1), 1'b0, 1'b0, 1'b1, 1'b0);

            if (k == abort_k) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                exp_cnt = '0;
                chk_reset({tag, ".rst_async"});
                return;
            end

            start = 1'b0;
            if (noise == 1) begin
                start        = ($urandom_range(0, 2) == 0);
                op           = 2'($urandom_range(0, 3));
                divisor_zero = 1'($urandom_range(0, 1));
            end else if (noise == 2 && (k == 5 || k == n + 2)) begin
                start        = 1'b1;
                op           = 2'b10;
                divisor_zero = 1'b0;
            end
            @(negedge clk);
        end
        if (!rej) exp_cnt = CNT_W'(n - 1);
        start = 1'b0;
    endtask

    initial begin
        exp_cnt = '0;
        exp_opq = 2'b00;
        #1;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult", 2'b00, 1'b0, 0, 0);
        run_op("sqrt", 2'b10, 1'b1, 0, 0);
        run_op("div", 2'b01, 1'b0, 0, 0);
        run_op("div0", 2'b01, 1'b1, 0, 0);
        run_op("ill", 2'b11, 1'b0, 0, 0);
        run_op("busy_start", 2'b00, 1'b0, 2, 0);
        run_op("after_busy", 2'b10, 1'b0, 0, 0);

        run_op("abort", 2'b00, 1'b0, 0, 7);
        @(negedge clk);
        chk_reset("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 2'b00, 1'b0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] ro;
            logic       rdz;
            ro  = 2'($urandom_range(0, 3));
            rdz = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), ro, rdz, 1, 0);
        end

        chk_cycle("final_idle", 2'b10, 1'b0, 1'b1, exp_cnt, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
